// File: rtl/stroke_stepper_pkg.sv
// Shared types and widths for the stroke stepper and the painter stage behind it.
// Also holds the absolute-difference helpers used when a segment is set up.
package stroke_stepper_pkg;

  localparam int H_W   = 11;
  localparam int V_W   = 10;
  localparam int R_W   = 16;
  localparam int DX_W  = H_W + 1;
  localparam int DY_W  = V_W + 1;
  localparam int ERR_W = H_W + 2;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    NO_PREV = 3'd0,
    HOLD    = 3'd1,
    SETUP   = 3'd2,
    STEP    = 3'd3,
    ISSUE   = 3'd4
  } state_e;

  function automatic logic [H_W-1:0] abs_diff_h(input logic [H_W-1:0] a, input logic [H_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [V_W-1:0] abs_diff_v(input logic [V_W-1:0] a, input logic [V_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/stroke_stepper_if.sv
// Sample-in / dab-out handshake bundle; slave is the stepper's view, master the
// view of whatever drives samples and consumes dabs.
interface stroke_stepper_if;
  import stroke_stepper_pkg::*;

  logic [H_W-1:0] point_x_in;
  logic [V_W-1:0] point_y_in;
  logic           pen_down_in;
  logic [R_W-1:0] radius_in;
  logic           point_valid_in;
  logic           point_ready_out;
  logic [H_W-1:0] hcount_out;
  logic [V_W-1:0] vcount_out;
  logic [R_W-1:0] radius_out;
  logic           data_valid_out;
  logic           ready_in;

  modport slave (
    input  point_x_in, point_y_in, pen_down_in, radius_in, point_valid_in, ready_in,
    output point_ready_out, hcount_out, vcount_out, radius_out, data_valid_out
  );

  modport master (
    output point_x_in, point_y_in, pen_down_in, radius_in, point_valid_in, ready_in,
    input  point_ready_out, hcount_out, vcount_out, radius_out, data_valid_out
  );

endinterface

// File: rtl/bresenham_step.sv
// One combinational Bresenham iteration: next x, y and error term from the
// current position, the segment deltas and the step directions.
module bresenham_step
  import stroke_stepper_pkg::*;
(
  input  logic [H_W-1:0]          x_i,
  input  logic [V_W-1:0]          y_i,
  input  logic signed [ERR_W-1:0] err_i,
  input  logic signed [DX_W-1:0]  dx_i,
  input  logic signed [DY_W-1:0]  dy_i,
  input  logic                    sx_neg_i,
  input  logic                    sy_neg_i,
  output logic [H_W-1:0]          x_o,
  output logic [V_W-1:0]          y_o,
  output logic signed [ERR_W-1:0] err_o
);

  // One guard bit above the error width keeps 2*err and the sums exact.
  logic signed [ERR_W:0] e2_s;
  logic signed [ERR_W:0] dx_ext_s;
  logic signed [ERR_W:0] dy_ext_s;
  logic signed [ERR_W:0] err_acc_s;

  always_comb begin
    e2_s      = {err_i, 1'b0};
    dx_ext_s  = {{(ERR_W + 1 - DX_W){dx_i[DX_W-1]}}, dx_i};
    dy_ext_s  = {{(ERR_W + 1 - DY_W){dy_i[DY_W-1]}}, dy_i};
    err_acc_s = {err_i[ERR_W-1], err_i};
    if (e2_s >= dy_ext_s) begin
      x_o       = sx_neg_i ? (x_i - H_W'(1)) : (x_i + H_W'(1));
      err_acc_s = err_acc_s + dy_ext_s;
    end else begin
      x_o = x_i;
    end
    if (e2_s <= dx_ext_s) begin
      y_o       = sy_neg_i ? (y_i - V_W'(1)) : (y_i + V_W'(1));
      err_acc_s = err_acc_s + dx_ext_s;
    end else begin
      y_o = y_i;
    end
    err_o = err_acc_s[ERR_W-1:0];
  end

endmodule

// File: rtl/stroke_stepper.sv
// Stroke stepper: turns pen samples into Bresenham-walked brush dabs, one dab
// every SPACING steps plus the endpoint, handed to the painter stage by valid/ready.
module stroke_stepper
  import stroke_stepper_pkg::*;
#(
  parameter int SPACING = 1
) (
  input logic             clk_in,
  input logic             rst_in,
  stroke_stepper_if.slave bus
);

  state_e                  state_q;
  logic [H_W-1:0]          cur_x_q;
  logic [V_W-1:0]          cur_y_q;
  logic [H_W-1:0]          end_x_q;
  logic [V_W-1:0]          end_y_q;
  logic [R_W-1:0]          radius_q;
  logic [H_W-1:0]          hcount_q;
  logic [V_W-1:0]          vcount_q;
  logic signed [DX_W-1:0]  dx_q;
  logic signed [DY_W-1:0]  dy_q;
  logic signed [ERR_W-1:0] err_q;
  logic                    sx_neg_q;
  logic                    sy_neg_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    valid_q;
  logic                    ready_q;

  logic [H_W-1:0]          step_x_d;
  logic [V_W-1:0]          step_y_d;
  logic signed [ERR_W-1:0] step_err_d;
  logic signed [DX_W-1:0]  setup_dx_s;
  logic signed [DY_W-1:0]  setup_dy_s;
  logic signed [ERR_W-1:0] setup_err_s;
  logic                    accept_s;
  logic                    at_end_s;
  logic                    step_at_end_s;
  logic                    cnt_hit_s;

  bresenham_step u_step (
    .x_i      (cur_x_q),
    .y_i      (cur_y_q),
    .err_i    (err_q),
    .dx_i     (dx_q),
    .dy_i     (dy_q),
    .sx_neg_i (sx_neg_q),
    .sy_neg_i (sy_neg_q),
    .x_o      (step_x_d),
    .y_o      (step_y_d),
    .err_o    (step_err_d)
  );

  // Segment parameters derived from the held point and the new endpoint.
  always_comb begin
    setup_dx_s  = $signed({1'b0, abs_diff_h(end_x_q, cur_x_q)});
    setup_dy_s  = -$signed({1'b0, abs_diff_v(end_y_q, cur_y_q)});
    setup_err_s = $signed({setup_dx_s[DX_W-1], setup_dx_s})
                + $signed({{(ERR_W - DY_W){setup_dy_s[DY_W-1]}}, setup_dy_s});
  end

  assign accept_s      = bus.point_valid_in & ready_q;
  assign at_end_s      = (cur_x_q == end_x_q) && (cur_y_q == end_y_q);
  assign step_at_end_s = (step_x_d == end_x_q) && (step_y_d == end_y_q);
  assign cnt_hit_s     = (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) == (CNT_W + 1)'(SPACING));

  // Control FSM; every handshake and dab output comes straight from a register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= NO_PREV;
      cur_x_q  <= {H_W{1'b0}};
      cur_y_q  <= {V_W{1'b0}};
      end_x_q  <= {H_W{1'b0}};
      end_y_q  <= {V_W{1'b0}};
      radius_q <= {R_W{1'b0}};
      hcount_q <= {H_W{1'b0}};
      vcount_q <= {V_W{1'b0}};
      dx_q     <= {DX_W{1'b0}};
      dy_q     <= {DY_W{1'b0}};
      err_q    <= {ERR_W{1'b0}};
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      case (state_q)
        NO_PREV: begin
          if (accept_s && bus.pen_down_in) begin
            cur_x_q  <= bus.point_x_in;
            cur_y_q  <= bus.point_y_in;
            end_x_q  <= bus.point_x_in;
            end_y_q  <= bus.point_y_in;
            radius_q <= bus.radius_in;
            hcount_q <= bus.point_x_in;
            vcount_q <= bus.point_y_in;
            valid_q  <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= ISSUE;
          end else begin
            state_q <= NO_PREV;
          end
        end
        HOLD: begin
          if (accept_s && bus.pen_down_in) begin
            end_x_q  <= bus.point_x_in;
            end_y_q  <= bus.point_y_in;
            radius_q <= bus.radius_in;
            ready_q  <= 1'b0;
            state_q  <= SETUP;
          end else if (accept_s) begin
            state_q <= NO_PREV;
          end else begin
            state_q <= HOLD;
          end
        end
        SETUP: begin
          dx_q     <= setup_dx_s;
          dy_q     <= setup_dy_s;
          err_q    <= setup_err_s;
          sx_neg_q <= (end_x_q < cur_x_q);
          sy_neg_q <= (end_y_q < cur_y_q);
          cnt_q    <= {CNT_W{1'b0}};
          state_q  <= STEP;
        end
        STEP: begin
          // Only a repeated sample reaches STEP already sitting on the endpoint.
          if (at_end_s) begin
            ready_q <= 1'b1;
            state_q <= HOLD;
          end else begin
            cur_x_q <= step_x_d;
            cur_y_q <= step_y_d;
            err_q   <= step_err_d;
            if (step_at_end_s || cnt_hit_s) begin
              cnt_q    <= {CNT_W{1'b0}};
              hcount_q <= step_x_d;
              vcount_q <= step_y_d;
              valid_q  <= 1'b1;
              state_q  <= ISSUE;
            end else begin
              cnt_q   <= cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
              state_q <= STEP;
            end
          end
        end
        ISSUE: begin
          if (bus.ready_in) begin
            valid_q <= 1'b0;
            if (at_end_s) begin
              ready_q <= 1'b1;
              state_q <= HOLD;
            end else begin
              state_q <= STEP;
            end
          end else begin
            state_q <= ISSUE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= NO_PREV;
        end
      endcase
    end
  end

  assign bus.point_ready_out = ready_q;
  assign bus.data_valid_out  = valid_q;
  assign bus.hcount_out      = hcount_q;
  assign bus.vcount_out      = vcount_q;
  assign bus.radius_out      = radius_q;

endmodule

// File: tb/tb_stroke_stepper.sv
// Scoreboard bench: two steppers (SPACING 1 and 3) share one sample source; a
// plain-integer Bresenham model predicts dabs and a monitor checks each transfer.
module tb_stroke_stepper;
  import stroke_stepper_pkg::*;

  typedef struct {
    int x;
    int y;
    int r;
  } dab_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [10:0] px;
  logic [9:0]  py;
  logic        pen;
  logic [15:0] rad;
  logic        pv;
  int          sel;
  logic        rdy;
  int          rdy_mode;

  int checks = 0;
  int errors = 0;

  stroke_stepper_if bus0 ();
  stroke_stepper_if bus1 ();

  assign bus0.point_x_in     = px;
  assign bus0.point_y_in     = py;
  assign bus0.pen_down_in    = pen;
  assign bus0.radius_in      = rad;
  assign bus0.point_valid_in = pv && (sel == 0);
  assign bus0.ready_in       = rdy;
  assign bus1.point_x_in     = px;
  assign bus1.point_y_in     = py;
  assign bus1.pen_down_in    = pen;
  assign bus1.radius_in      = rad;
  assign bus1.point_valid_in = pv && (sel == 1);
  assign bus1.ready_in       = rdy;

  stroke_stepper #(.SPACING(1)) dut0 (.clk_in(clk), .rst_in(rst_n), .bus(bus0));
  stroke_stepper #(.SPACING(3)) dut1 (.clk_in(clk), .rst_in(rst_n), .bus(bus1));

  logic [10:0] hc [2];
  logic [9:0]  vc [2];
  logic [15:0] ro [2];
  logic [1:0]  dv;
  logic [1:0]  pr;
  assign hc[0] = bus0.hcount_out;
  assign hc[1] = bus1.hcount_out;
  assign vc[0] = bus0.vcount_out;
  assign vc[1] = bus1.vcount_out;
  assign ro[0] = bus0.radius_out;
  assign ro[1] = bus1.radius_out;
  assign dv    = {bus1.data_valid_out, bus0.data_valid_out};
  assign pr    = {bus1.point_ready_out, bus0.point_ready_out};

  dab_t q0[$];
  dab_t q1[$];
  int   held_x [2];
  int   held_y [2];
  bit   has_prev [2];
  int   spacing [2] = '{1, 3};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input int k, input int x, input int y, input int r);
    dab_t d;
    d.x = x;
    d.y = y;
    d.r = r;
    if (k == 0) q0.push_back(d);
    else q1.push_back(d);
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic dab_t pop_exp(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  // Walk the line from (x0,y0) to (x1,y1); keep every spacing-th point and the end.
  function automatic void model_segment(input int k, input int x0, input int y0,
                                        input int x1, input int y1, input int r);
    int dx, dy, sx, sy, err, e2, x, y, cnt;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx  = (x1 >= x0) ? 1 : -1;
    sy  = (y1 >= y0) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    cnt = 0;
    while (!(x == x1 && y == y1)) begin
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
      cnt++;
      if (cnt == spacing[k] || (x == x1 && y == y1)) begin
        push_exp(k, x, y, r);
        cnt = 0;
      end
    end
  endfunction

  // Dab monitor: checks every transfer against the queue plus hold/post-transfer rules.
  bit prev_v [2];
  bit prev_x [2];
  int prev_h [2];
  int prev_vv [2];
  int prev_r [2];
  always @(negedge clk) begin
    dab_t d;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        prev_v[k] <= 1'b0;
        prev_x[k] <= 1'b0;
      end else begin
        if (prev_x[k]) begin
          chk("post_transfer_valid", int'(dv[k]), 0);
        end else if (prev_v[k]) begin
          chk("hold_valid", int'(dv[k]), 1);
          chk("hold_x", int'(hc[k]), prev_h[k]);
          chk("hold_y", int'(vc[k]), prev_vv[k]);
          chk("hold_r", int'(ro[k]), prev_r[k]);
        end
        if (dv[k] && rdy) begin
          if (qsize(k) == 0) begin
            chk("unexpected_dab_x", int'(hc[k]), -1);
          end else begin
            d = pop_exp(k);
            chk("dab_x", int'(hc[k]), d.x);
            chk("dab_y", int'(vc[k]), d.y);
            chk("dab_r", int'(ro[k]), d.r);
          end
        end
        prev_v[k]  <= dv[k];
        prev_x[k]  <= dv[k] && rdy;
        prev_h[k]  <= int'(hc[k]);
        prev_vv[k] <= int'(vc[k]);
        prev_r[k]  <= int'(ro[k]);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send(input int k, input int x, input int y, input bit pd, input int r);
    int n;
    n = 0;
    @(negedge clk);
    while (pr[k] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("sample_accept_in_time", int'(n < 3000), 1);
    if (n < 3000) begin
      sel = k;
      px  = 11'(x);
      py  = 10'(y);
      pen = pd;
      rad = 16'(r);
      pv  = 1'b1;
      if (!pd) begin
        has_prev[k] = 1'b0;
      end else if (!has_prev[k]) begin
        push_exp(k, x, y, r);
        has_prev[k] = 1'b1;
      end else begin
        model_segment(k, held_x[k], held_y[k], x, y, r);
      end
      if (pd) begin
        held_x[k] = x;
        held_y[k] = y;
      end
      @(negedge clk);
      pv = 1'b0;
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!(qsize(k) == 0 && pr[k] == 1'b1 && dv[k] == 1'b0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_time", int'(n < 5000), 1);
    chk("queue_drained", qsize(k), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_h, hold_v, hold_r, k, x, y;
    bit pd;
    rst_n    = 1'b0;
    px       = '0;
    py       = '0;
    pen      = 1'b0;
    rad      = '0;
    pv       = 1'b0;
    sel      = 0;
    rdy      = 1'b0;
    rdy_mode = 1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_valid", int'(dv[i]), 0);
      chk("reset_ready", int'(pr[i]), 1);
      chk("reset_hcount", int'(hc[i]), 0);
      chk("reset_vcount", int'(vc[i]), 0);
      chk("reset_radius", int'(ro[i]), 0);
    end
    rst_n = 1'b1;

    // First point, straight run, reverse diagonal, spaced run.
    send(0, 100, 50, 1'b1, 5);
    wait_idle(0);
    chk("s1_ready_after", int'(pr[0]), 1);
    send(0, 104, 50, 1'b1, 5);
    wait_idle(0);
    send(0, 0, 0, 1'b0, 0);
    send(0, 10, 20, 1'b1, 7);
    send(0, 7, 24, 1'b1, 9);
    wait_idle(0);
    send(1, 0, 0, 1'b1, 3);
    send(1, 7, 0, 1'b1, 3);
    wait_idle(1);

    // Repeated point: no dab, ready again two cycles after the transfer.
    send(0, 7, 24, 1'b1, 9);
    chk("repeat_busy_c0", int'(pr[0]), 0);
    @(negedge clk);
    chk("repeat_busy_c1", int'(pr[0]), 0);
    @(negedge clk);
    chk("repeat_ready_c2", int'(pr[0]), 1);
    chk("repeat_no_dab", int'(dv[0]), 0);

    // Painter stalled for 20 cycles mid-segment.
    rdy_mode = 0;
    send(0, 30, 24, 1'b1, 4);
    repeat (4) @(negedge clk);
    chk("stall_valid", int'(dv[0]), 1);
    hold_h = int'(hc[0]);
    hold_v = int'(vc[0]);
    hold_r = int'(ro[0]);
    repeat (20) @(negedge clk);
    chk("stall_valid_end", int'(dv[0]), 1);
    chk("stall_x", int'(hc[0]), hold_h);
    chk("stall_y", int'(vc[0]), hold_v);
    chk("stall_r", int'(ro[0]), hold_r);
    rdy_mode = 2;
    wait_idle(0);

    for (int i = 0; i < 40; i++) begin
      k  = int'($urandom_range(0, 1));
      pd = ($urandom_range(0, 5) != 0);
      x  = int'($urandom_range(0, 40));
      y  = int'($urandom_range(0, 40));
      if (has_prev[k] && $urandom_range(0, 7) == 0) begin
        x = held_x[k];
        y = held_y[k];
      end
      send(k, x, y, pd, int'($urandom_range(0, 65535)));
    end
    wait_idle(0);
    wait_idle(1);

    // Reset in the middle of a stalled segment.
    rdy_mode = 1;
    send(0, 290, 90, 1'b1, 11);
    wait_idle(0);
    rdy_mode = 0;
    send(0, 300, 100, 1'b1, 11);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", int'(dv[0]), 0);
    chk("midreset_ready", int'(pr[0]), 1);
    chk("midreset_hcount", int'(hc[0]), 0);
    chk("midreset_vcount", int'(vc[0]), 0);
    chk("midreset_radius", int'(ro[0]), 0);
    q0.delete();
    q1.delete();
    has_prev[0] = 1'b0;
    has_prev[1] = 1'b0;
    @(negedge clk);
    #2;
    rst_n    = 1'b1;
    rdy_mode = 1;
    send(0, 5, 5, 1'b1, 2);
    wait_idle(0);
    repeat (3) @(negedge clk);
    chk("after_reset_single_dab", int'(dv[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
